// File: rtl/snake_pkg.sv
// Shared encodings for the snake motion engine: game status, direction codes
// and grid coordinate widths.
package snake_pkg;

    localparam int X_W = 6;
    localparam int Y_W = 5;

    typedef enum logic [1:0] {
        ST_START   = 2'b00,
        ST_RESTART = 2'b01,
        ST_PLAY    = 2'b10,
        ST_DIE     = 2'b11
    } game_status_t;

    // Opposite directions differ only in bit 0.
    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    function automatic dir_t reverse_dir(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/bcd_counter3.sv
// Three-digit BCD score counter: synchronous clear, increment enable,
// decimal carry between digits, saturating at 999.
module bcd_counter3 (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        inc,
    output logic [11:0] bcd
);

    logic [11:0] bcd_reg;
    logic [11:0] bcd_next;
    logic [2:0]  carry;
    logic        saturated;

    assign carry[0]  = 1'b1;
    assign saturated = (bcd_reg == 12'h999);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_digit
            logic [3:0] digit;
            logic       at_nine;
            assign digit   = bcd_reg[gi*4 +: 4];
            assign at_nine = (digit == 4'd9);
            assign bcd_next[gi*4 +: 4] = carry[gi] ? (at_nine ? 4'd0 : digit + 4'd1) : digit;
            if (gi < 2) begin : g_carry
                assign carry[gi+1] = carry[gi] & at_nine;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_reg <= 12'h000;
        end else if (clr) begin
            bcd_reg <= 12'h000;
        end else if (inc && !saturated) begin
            bcd_reg <= bcd_next;
        end
    end

    assign bcd = bcd_reg;

endmodule

// File: rtl/snake_motion_unit.sv
// Snake motion and collision engine with per-pixel snake queries.
// Define SNAKE_WRAP_EN to make the grid edges wrap instead of acting as walls.
module snake_motion_unit
    import snake_pkg::*;
#(
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int STEP_DIV = 12_500_000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     game_status,
    input  logic           key0_right,
    input  logic           key1_left,
    input  logic           key2_down,
    input  logic           key3_up,
    input  logic [X_W-1:0] apple_x,
    input  logic [Y_W-1:0] apple_y,
    input  logic           apple_valid,
    input  logic [X_W-1:0] pix_x,
    input  logic [Y_W-1:0] pix_y,
    output logic           is_snake,
    output logic           is_head,
    output logic           apple_eaten,
    output logic           hit_wall,
    output logic           hit_body,
    output logic [11:0]    bcd_data
);

    localparam int TICK_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam logic [X_W-1:0] HOME_X = X_W'(GRID_W / 2);
    localparam logic [Y_W-1:0] HOME_Y = Y_W'(GRID_H / 2);
`ifdef SNAKE_WRAP_EN
    localparam bit WALLS_ON = 1'b0;
`else
    localparam bit WALLS_ON = 1'b1;
`endif

    game_status_t status;
    assign status = game_status_t'(game_status);

    // Segment 0 is the head; entries at index >= len_reg are don't-care.
    logic [MAX_LEN-1:0][X_W-1:0] seg_x_reg;
    logic [MAX_LEN-1:0][Y_W-1:0] seg_y_reg;
    logic [MAX_LEN-1:0][X_W-1:0] init_x;
    logic [LEN_W-1:0]  len_reg;
    dir_t              cur_dir_reg;
    dir_t              pend_dir_reg;
    logic [TICK_W-1:0] tick_reg;
    logic              hit_wall_reg, hit_body_reg, eaten_reg;
    logic              is_snake_reg, is_head_reg;

    dir_t              key_dir;
    logic              key_any;
    logic              step, wall_block, body_hit, grow, move;
    logic [X_W-1:0]    next_x;
    logic [Y_W-1:0]    next_y;
    logic [MAX_LEN-1:0] body_match, query_match;

    always_comb begin
        key_any = 1'b1;
        key_dir = DIR_RIGHT;
        if (!key3_up)         key_dir = DIR_UP;
        else if (!key2_down)  key_dir = DIR_DOWN;
        else if (!key1_left)  key_dir = DIR_LEFT;
        else if (!key0_right) key_dir = DIR_RIGHT;
        else                  key_any = 1'b0;
    end

    assign step = (status == ST_PLAY) && (tick_reg == TICK_W'(STEP_DIV - 1));

    // The step always travels in the pending direction; edge cells either
    // block the move or wrap to the opposite side.
    always_comb begin
        next_x     = seg_x_reg[0];
        next_y     = seg_y_reg[0];
        wall_block = 1'b0;
        case (pend_dir_reg)
            DIR_UP: begin
                if (seg_y_reg[0] == '0) begin
                    next_y     = Y_W'(GRID_H - 1);
                    wall_block = WALLS_ON;
                end else begin
                    next_y = seg_y_reg[0] - 1'b1;
                end
            end
            DIR_DOWN: begin
                if (seg_y_reg[0] == Y_W'(GRID_H - 1)) begin
                    next_y     = '0;
                    wall_block = WALLS_ON;
                end else begin
                    next_y = seg_y_reg[0] + 1'b1;
                end
            end
            DIR_LEFT: begin
                if (seg_x_reg[0] == '0) begin
                    next_x     = X_W'(GRID_W - 1);
                    wall_block = WALLS_ON;
                end else begin
                    next_x = seg_x_reg[0] - 1'b1;
                end
            end
            default: begin
                if (seg_x_reg[0] == X_W'(GRID_W - 1)) begin
                    next_x     = '0;
                    wall_block = WALLS_ON;
                end else begin
                    next_x = seg_x_reg[0] + 1'b1;
                end
            end
        endcase
    end

    assign grow = apple_valid && (next_x == apple_x) && (next_y == apple_y);

    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_seg
            assign init_x[gi] = HOME_X - X_W'((gi < INIT_LEN) ? gi : INIT_LEN - 1);
            // Without growth the tail vacates its cell in the same step.
            assign body_match[gi] = (LEN_W'(gi) < len_reg)
                                  && (grow || (LEN_W'(gi + 1) != len_reg))
                                  && (seg_x_reg[gi] == next_x) && (seg_y_reg[gi] == next_y);
            assign query_match[gi] = (LEN_W'(gi) < len_reg)
                                   && (seg_x_reg[gi] == pix_x) && (seg_y_reg[gi] == pix_y);
        end
    endgenerate

    assign body_hit = |body_match;
    assign move     = step && !wall_block && !body_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_x_reg <= init_x;
            seg_y_reg <= {MAX_LEN{HOME_Y}};
        end else if (status == ST_RESTART) begin
            seg_x_reg <= init_x;
            seg_y_reg <= {MAX_LEN{HOME_Y}};
        end else if (move) begin
            seg_x_reg <= {seg_x_reg[MAX_LEN-2:0], next_x};
            seg_y_reg <= {seg_y_reg[MAX_LEN-2:0], next_y};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_reg      <= LEN_W'(INIT_LEN);
            cur_dir_reg  <= DIR_RIGHT;
            pend_dir_reg <= DIR_RIGHT;
            tick_reg     <= '0;
            hit_wall_reg <= 1'b0;
            hit_body_reg <= 1'b0;
            eaten_reg    <= 1'b0;
        end else begin
            eaten_reg <= 1'b0;
            case (status)
                ST_RESTART: begin
                    len_reg      <= LEN_W'(INIT_LEN);
                    cur_dir_reg  <= DIR_RIGHT;
                    pend_dir_reg <= DIR_RIGHT;
                    tick_reg     <= '0;
                    hit_wall_reg <= 1'b0;
                    hit_body_reg <= 1'b0;
                end
                ST_START: begin
                    tick_reg <= '0;
                    if (key_any) pend_dir_reg <= key_dir;
                end
                ST_PLAY: begin
                    tick_reg <= step ? '0 : tick_reg + 1'b1;
                    if (key_any && (key_dir != reverse_dir(cur_dir_reg))) begin
                        pend_dir_reg <= key_dir;
                    end
                    if (step) begin
                        cur_dir_reg <= pend_dir_reg;
                        if (wall_block) begin
                            hit_wall_reg <= 1'b1;
                        end else if (body_hit) begin
                            hit_body_reg <= 1'b1;
                        end else if (grow) begin
                            eaten_reg <= 1'b1;
                            if (len_reg < LEN_W'(MAX_LEN)) len_reg <= len_reg + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_snake_reg <= 1'b0;
            is_head_reg  <= 1'b0;
        end else begin
            is_snake_reg <= |query_match;
            is_head_reg  <= (seg_x_reg[0] == pix_x) && (seg_y_reg[0] == pix_y);
        end
    end

    bcd_counter3 u_score (
        .clk (clk),
        .rst (rst),
        .clr (status == ST_RESTART),
        .inc (move && grow),
        .bcd (bcd_data)
    );

    assign is_snake    = is_snake_reg;
    assign is_head     = is_head_reg;
    assign apple_eaten = eaten_reg;
    assign hit_wall    = hit_wall_reg;
    assign hit_body    = hit_body_reg;

endmodule

// File: tb/tb_snake_motion_unit.sv
// Self-checking bench for snake_motion_unit: queue-based reference model,
// per-cycle output compare, directed scenarios and a randomized phase.
`timescale 1ns/1ps
module tb_snake_motion_unit;

    localparam int W  = 40;
    localparam int H  = 30;
    localparam int ML = 16;
    localparam int IL = 3;
    localparam int SD = 4;

    localparam logic [1:0] S_START   = 2'b00;
    localparam logic [1:0] S_RESTART = 2'b01;
    localparam logic [1:0] S_PLAY    = 2'b10;
    localparam logic [1:0] S_DIE     = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  game_status = S_START;
    logic        key0_right = 1'b1, key1_left = 1'b1, key2_down = 1'b1, key3_up = 1'b1;
    logic [5:0]  apple_x = '0;
    logic [4:0]  apple_y = '0;
    logic        apple_valid = 1'b0;
    logic [5:0]  pix_x = '0;
    logic [4:0]  pix_y = '0;
    logic        is_snake, is_head, apple_eaten, hit_wall, hit_body;
    logic [11:0] bcd_data;

    always #5 clk = ~clk;

    snake_motion_unit #(.STEP_DIV(SD)) dut (
        .clk(clk), .rst(rst), .game_status(game_status),
        .key0_right(key0_right), .key1_left(key1_left), .key2_down(key2_down), .key3_up(key3_up),
        .apple_x(apple_x), .apple_y(apple_y), .apple_valid(apple_valid),
        .pix_x(pix_x), .pix_y(pix_y),
        .is_snake(is_snake), .is_head(is_head), .apple_eaten(apple_eaten),
        .hit_wall(hit_wall), .hit_body(hit_body), .bcd_data(bcd_data)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: snake as a queue of cells, head at the front.
    typedef struct { int x; int y; } cell_t;
    cell_t snake[$];
    int  m_dx, m_dy, p_dx, p_dy, m_tick, m_score, m_eats;
    bit  m_wall, m_body, e_eaten, e_snake, e_head;

    task automatic model_init();
        snake.delete();
        for (int i = 0; i < IL; i++) snake.push_back('{W/2 - i, H/2});
        m_dx = 1; m_dy = 0; p_dx = 1; p_dy = 0; m_tick = 0;
    endtask

    function automatic bit cell_in(input int x, input int y, input int n);
        for (int i = 0; i < n; i++)
            if (snake[i].x == x && snake[i].y == y) return 1'b1;
        return 1'b0;
    endfunction

    task automatic get_key(output bit any, output int kx, output int ky);
        any = 1'b1; kx = 0; ky = 0;
        if (!key3_up)         ky = -1;
        else if (!key2_down)  ky = 1;
        else if (!key1_left)  kx = -1;
        else if (!key0_right) kx = 1;
        else                  any = 1'b0;
    endtask

    task automatic model_play();
        bit any, accept, step, grow;
        int kx, ky, nx, ny;
        step = (m_tick == SD - 1);
        m_tick = step ? 0 : m_tick + 1;
        get_key(any, kx, ky);
        accept = any && !(kx == -m_dx && ky == -m_dy);
        if (step) begin
            m_dx = p_dx; m_dy = p_dy;
            nx = snake[0].x + m_dx;
            ny = snake[0].y + m_dy;
`ifdef SNAKE_WRAP_EN
            nx = (nx + W) % W;
            ny = (ny + H) % H;
`endif
            if (nx < 0 || nx >= W || ny < 0 || ny >= H) begin
                m_wall = 1'b1;
            end else begin
                grow = apple_valid && nx == int'(apple_x) && ny == int'(apple_y);
                if (cell_in(nx, ny, grow ? snake.size() : snake.size() - 1)) begin
                    m_body = 1'b1;
                end else begin
                    snake.push_front('{nx, ny});
                    if (!grow || snake.size() > ML) void'(snake.pop_back());
                    if (grow) begin
                        e_eaten = 1'b1;
                        m_eats++;
                        if (m_score < 999) m_score++;
                    end
                end
            end
        end
        if (accept) begin p_dx = kx; p_dy = ky; end
    endtask

    always @(posedge clk) begin
        bit any;
        int kx, ky;
        if (rst) begin
            model_init();
            m_wall = 0; m_body = 0; m_score = 0; m_eats = 0;
            e_eaten = 0; e_snake = 0; e_head = 0;
        end else begin
            e_snake = cell_in(int'(pix_x), int'(pix_y), snake.size());
            e_head  = (snake[0].x == int'(pix_x)) && (snake[0].y == int'(pix_y));
            e_eaten = 1'b0;
            case (game_status)
                S_RESTART: begin
                    model_init();
                    m_wall = 0; m_body = 0; m_score = 0; m_eats = 0;
                end
                S_START: begin
                    m_tick = 0;
                    get_key(any, kx, ky);
                    if (any) begin p_dx = kx; p_dy = ky; end
                end
                S_PLAY: model_play();
                default: ;
            endcase
        end
    end

    function automatic int score_bcd(input int s);
        return (s / 100) * 256 + ((s / 10) % 10) * 16 + (s % 10);
    endfunction

    always @(posedge clk) begin
        #1;
        check("hit_wall", hit_wall, m_wall);
        check("hit_body", hit_body, m_body);
        check("bcd_data", bcd_data, score_bcd(m_score));
        check("apple_eaten", apple_eaten, e_eaten);
        check("is_snake", is_snake, e_snake);
        check("is_head", is_head, e_head);
    end

    // Stimulus helpers; all called at a falling edge.
    task automatic run(input logic [1:0] st, input int n);
        game_status = st;
        repeat (n) @(negedge clk);
    endtask

    task automatic set_key(input int dx, input int dy);
        key0_right = !(dx == 1);
        key1_left  = !(dx == -1);
        key2_down  = !(dy == 1);
        key3_up    = !(dy == -1);
    endtask

    task automatic query(input int x, input int y, input bit es, input bit eh, input string name);
        pix_x = 6'(x); pix_y = 5'(y);
        @(negedge clk);
        check({name, "_snake"}, is_snake, es);
        check({name, "_head"}, is_head, eh);
    endtask

    task automatic set_apple(input int x, input int y, input bit v);
        apple_x = 6'(x); apple_y = 5'(y); apple_valid = v;
    endtask

    // Hamiltonian tour of the grid, used to eat an apple on every step.
    task automatic tour_dir(input int x, input int y, output int dx, output int dy);
        dx = 0; dy = 0;
        if (x == 0)           begin if (y == 0) dx = 1; else dy = -1; end
        else if (y % 2 == 0)  begin if (x == W-1) dy = 1; else dx = 1; end
        else if (x == 1)      begin if (y == H-1) dx = -1; else dy = 1; end
        else                  dx = -1;
    endtask

    initial begin
        int pulses, dx, dy, ax, ay, exp_x;
        bit seen10, seen100;
        logic [3:0] kbits;

        repeat (3) @(negedge clk);
        check("reset_bcd", bcd_data, 12'h000);
        check("reset_wall", hit_wall, 1'b0);
        check("reset_is_snake", is_snake, 1'b0);
        rst = 1'b0;

        // Initial move: two steps to the right.
        pix_x = 6'd21; pix_y = 5'd15;
        run(S_RESTART, 2);
        run(S_PLAY, 4);
        run(S_START, 1);
        query(21, 15, 1, 1, "move1");
        run(S_PLAY, 4);
        run(S_START, 1);
        query(22, 15, 1, 1, "move2");
        query(20, 15, 1, 0, "move2_tail");
        query(19, 15, 0, 0, "move2_past_len");

        // Reverse key rejected, then a legal turn up.
        set_key(-1, 0); run(S_PLAY, 4); set_key(0, 0); run(S_START, 1);
        query(23, 15, 1, 1, "rev_rejected");
        set_key(0, -1); run(S_PLAY, 4); set_key(0, 0); run(S_START, 1);
        query(23, 14, 1, 1, "turn_up");

        // Run into the right edge (or wrap around it).
        run(S_RESTART, 2);
        run(S_PLAY, 80);
`ifdef SNAKE_WRAP_EN
        exp_x = 0;
        check("edge_flag", hit_wall, 1'b0);
`else
        exp_x = 39;
        check("edge_flag", hit_wall, 1'b1);
`endif
        game_status = S_DIE;
        query(exp_x, 15, 1, 1, "edge_head");
        run(S_DIE, 5);
        check("edge_hold_die", hit_wall, WALLS_EXPECTED());
        run(S_RESTART, 1);
        check("edge_cleared", hit_wall, 1'b0);

        // Growth and score.
        run(S_RESTART, 1);
        set_apple(21, 15, 1);
        game_status = S_PLAY;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (apple_eaten === 1'b1) pulses++;
        end
        check("eat_pulses", pulses, 1);
        apple_valid = 1'b0;
        run(S_START, 1);
        check("eat_score", bcd_data, 12'h001);
        query(18, 15, 1, 0, "grow_tail");
        query(17, 15, 0, 0, "grow_past_len");

        // Moving into the vacating tail cell is legal.
        set_key(0, -1); run(S_PLAY, 4);
        set_key(-1, 0); run(S_PLAY, 4);
        set_key(0, 1);  run(S_PLAY, 4);
        set_key(0, 0);  run(S_START, 1);
        check("tail_no_hit", hit_body, 1'b0);
        query(20, 15, 1, 1, "tail_head");

        // Self collision at length 5.
        run(S_RESTART, 2);
        set_apple(21, 15, 1); run(S_PLAY, 4);
        set_apple(22, 15, 1); run(S_PLAY, 4);
        apple_valid = 1'b0;
        set_key(0, -1); run(S_PLAY, 4);
        set_key(-1, 0); run(S_PLAY, 4);
        set_key(0, 1);  run(S_PLAY, 4);
        set_key(0, 0);  run(S_START, 1);
        check("self_hit", hit_body, 1'b1);
        check("self_hit_score", bcd_data, 12'h002);
        query(21, 14, 1, 1, "self_hit_nomove");

        // Eat on every step along a tour: BCD carries and saturation.
        run(S_RESTART, 2);
        game_status = S_PLAY;
        seen10 = 0; seen100 = 0;
        for (int cyc = 0; cyc < 6000 && m_eats < 1000; cyc++) begin
            tour_dir(snake[0].x, snake[0].y, dx, dy);
            if (dx == -m_dx && dy == -m_dy) begin dx = 0; dy = -1; end
            set_key(dx, dy);
            set_apple(snake[0].x + dx, snake[0].y + dy, 1);
            @(negedge clk);
            if (m_eats == 10 && !seen10) begin seen10 = 1; check("bcd_010", bcd_data, 12'h010); end
            if (m_eats == 100 && !seen100) begin seen100 = 1; check("bcd_100", bcd_data, 12'h100); end
        end
        if (m_eats < 1000) begin
            failures++;
            $display("FAIL bcd_tour_budget eats=%0d required=1000", m_eats);
        end
        check("bcd_sat_999", bcd_data, 12'h999);
        check("bcd_len_sat", snake.size(), ML);
        set_key(0, 0); apple_valid = 1'b0;

        // Randomized phase.
        run(S_RESTART, 2);
        game_status = S_PLAY;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 31) == 0) begin
                case ($urandom_range(0, 9))
                    0, 1:    game_status = S_RESTART;
                    2:       game_status = S_START;
                    3:       game_status = S_DIE;
                    default: game_status = S_PLAY;
                endcase
            end
            if ($urandom_range(0, 3) == 0) begin
                kbits = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 1) == 1) kbits = 4'hF;
                {key3_up, key2_down, key1_left, key0_right} = kbits;
            end
            if ($urandom_range(0, 5) == 0) begin
                ax = snake[0].x; ay = snake[0].y;
                case ($urandom_range(0, 3))
                    0: ax++; 1: ax--; 2: ay++; default: ay--;
                endcase
                if (ax >= 0 && ax < W && ay >= 0 && ay < H)
                    set_apple(ax, ay, $urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 1) == 0) begin
                ax = $urandom_range(0, snake.size() - 1);
                pix_x = 6'(snake[ax].x); pix_y = 5'(snake[ax].y);
            end else begin
                pix_x = 6'($urandom_range(0, 63)); pix_y = 5'($urandom_range(0, 31));
            end
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic bit WALLS_EXPECTED();
`ifdef SNAKE_WRAP_EN
        return 1'b0;
`else
        return 1'b1;
`endif
    endfunction

endmodule

// File: doc/snake_motion_unit.md
Name: snake_motion_unit

Overview:
- Snake motion and collision engine; the producer side of the game-control handshake.
- Consumes game_status and the direction keys, steps the snake on a fixed tick during PLAY, and generates hit_wall, hit_body and the 3-digit BCD score that the game controller evaluates.
- Also answers per-pixel "is snake" queries for the VGA renderer.
- Sits between the key debouncer and the game controller / display path.

Parameters:
- GRID_W, 40, grid columns; x range 0..GRID_W-1.
- GRID_H, 30, grid rows; y range 0..GRID_H-1.
- MAX_LEN, 16, segment storage depth; length saturates here.
- INIT_LEN, 3, length after RESTART; must be ≥2 and ≤MAX_LEN.
- STEP_DIV, 12_500_000, clk cycles per move step (0.5 s at 25 MHz).

Ports:
- clk, input, 1, 25 MHz system clock.
- rst, input, 1, asynchronous active-high reset.
- game_status, input, 2, 01 RESTART, 00 START, 10 PLAY, 11 DIE.
- key0_right / key1_left / key2_down / key3_up, input, 1 each, debounced, active-low.
- apple_x, input, 6, apple column.
- apple_y, input, 5, apple row.
- apple_valid, input, 1, apple present.
- pix_x, input, 6, renderer query column.
- pix_y, input, 5, renderer query row.
- is_snake, output, 1, query hit, registered; 1-cycle latency.
- is_head, output, 1, query hits the head, registered; 1-cycle latency.
- apple_eaten, output, 1, 1-cycle pulse when the head lands on the apple.
- hit_wall, output, 1, sticky wall-collision flag.
- hit_body, output, 1, sticky self-collision flag.
- bcd_data, output, 12, score as hundreds:tens:units BCD.

Behaviour:
- Reset values: all outputs 0; length = INIT_LEN; head = (GRID_W/2, GRID_H/2); body extends left; direction = RIGHT; tick counter = 0.
- RESTART:
  - Re-initialise position, length and direction as at reset.
  - Clear hit_wall, hit_body, bcd_data and the tick counter.
- START:
  - Snake is frozen; tick counter held at 0.
  - Key presses update the pending direction.
- PLAY:
  - The tick counter counts 0..STEP_DIV-1; a step fires on the cycle it wraps.
  - Key press (key low) latches the pending direction unless it is the reverse of the current direction.
  - Simultaneous keys resolve by priority: up > down > left > right.
  - At a step: current direction = pending direction, then compute next_head.
  - Wall: if next_head leaves the grid (x=0 moving left, x=GRID_W-1 moving right, and likewise for y), set hit_wall and do not move.
  - Growth: grow = apple_valid && next_head == apple.
  - Body: if next_head equals segment i for i in 0..len-1, set hit_body and do not move.
    - When not growing, the tail segment (i = len-1) is excluded from the compare.
  - Otherwise shift segments (seg[i] <= seg[i-1], seg[0] <= next_head).
  - When grow is true: length+1, saturating at MAX_LEN (at saturation the tail is dropped as normal); apple_eaten pulses the same cycle; score increments.
  - A wall check takes precedence over the body check in the same step.
- DIE:
  - Everything frozen.
  - hit flags and score are held until RESTART.
  - Query outputs keep working so the controller's blink sees the final snake.
- Score:
  - BCD increment with digit carry (009→010, 099→100).
  - Saturates at 999.
  - bcd_data[11:8] ≥ 1 is the game controller's win condition.
- game_status changing mid-step: a new state takes effect next cycle; a step only fires while the current state is PLAY.
- Query: is_snake = OR over i < len of (seg[i] == pix); is_head = (seg[0] == pix); both registered.
- Segments at index ≥ len are ignored.

Optional Feature:
- SNAKE_WRAP_EN defined:
  - Walls wrap: x=GRID_W-1 moving right goes to 0 (and similarly for the other three edges).
  - hit_wall is tied to 0.
  - Body collision is unchanged.
- SNAKE_WRAP_EN undefined: wall collision behaves as described under Behaviour.

Decomposition:
- Package snake_pkg holds:
  - game_status encodings RESTART/START/PLAY/DIE;
  - the 2-bit direction codes UP/DOWN/LEFT/RIGHT;
  - the coordinate widths (6/5).
- Sub-module bcd_counter3: synchronous clear, enable increment, 3-digit carry, saturation at 999.

Test Plan:
- Test STEP_DIV = 4 in all directed tests.
- Initial move: reset, RESTART, then PLAY with no keys → head moves (20,15) → (21,15) → (22,15) every 4 cycles; length 3.
- Reverse rejected: moving RIGHT, press key1_left → direction stays RIGHT. Then press key3_up → next step head y decrements.
- Wall hit: run the snake right until x=39; the next step gives hit_wall=1, head stays at 39, and the flag holds through DIE until RESTART.
- Growth and score: apple at (21,15) valid, start PLAY → at the first step apple_eaten pulses once, length 4, bcd_data = 0x001.
- BCD carry and win: preload 99 eats (or force the counter to 099), eat once → bcd_data = 0x100. Also check that 999 plus an eat stays 0x999.
- Self hit: length 5, sequence up, left, down → hit_body=1 and no move. In a separate case, moving into the vacating tail cell does NOT set hit_body.
- Wrap build (SNAKE_WRAP_EN): head at x=39 moving right → x=0, hit_wall=0.
